// File: rtl/dff_pkg.sv
// dff_pkg: shared types and helpers for the checked dual-rail pipeline.
package dff_pkg;

    // Default data width used for the stage record below.
    localparam int DFF_WIDTH = 8;

    // One pipeline stage: true rail, independent complement rail, valid.
    typedef struct packed {
        logic [DFF_WIDTH-1:0] t;
        logic [DFF_WIDTH-1:0] c;
        logic                 v;
    } dff_rec_t;

    // Width of an occupancy counter that can hold 0..depth inclusive.
    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dff_stage.sv
// dff_stage: one pipeline stage holding a true/complement pair plus valid.
// The complement rail is loaded from its own input and never derived from t,
// so a fault on either rail shows up as a pair mismatch.
module dff_stage
    import dff_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             chk_off,
    input  logic [WIDTH-1:0] ld_t,
    input  logic [WIDTH-1:0] ld_c,
    input  logic             ld_v,
    output logic [WIDTH-1:0] t,
    output logic [WIDTH-1:0] c,
    output logic             v,
    output logic             mismatch
);

    // Stage registers: reset/flush to the idle pair, otherwise load on enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t <= RESET_VAL;
            c <= ~RESET_VAL;
            v <= 1'b0;
        end else if (clr) begin
            t <= RESET_VAL;
            c <= ~RESET_VAL;
            v <= 1'b0;
        end else if (en) begin
            t <= ld_t;
            c <= ld_c;
            v <= ld_v;
        end
    end

    assign mismatch = (t != ~c);

    // Pair integrity; stands down once a deliberate fault has been injected.
    chk_pair: assert property (@(posedge clk) disable iff (rst || chk_off) t == ~c);

endmodule

// File: rtl/dff_pipe.sv
// dff_pipe: DEPTH-stage checked retiming chain with valid bits, stall,
// synchronous flush, occupancy count and a sticky dual-rail error flag.
module dff_pipe
    import dff_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      clr,
    input  logic                      in_valid,
    input  logic [WIDTH-1:0]          d,
    input  logic                      inj,
    output logic [WIDTH-1:0]          q,
    output logic [WIDTH-1:0]          qr,
    output logic                      out_valid,
    output logic [occ_w(DEPTH)-1:0]   occ,
    output logic                      err
);

    localparam int OW = occ_w(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] t_a, c_a, ld_t, ld_c;
    logic [DEPTH-1:0]            v_a, ld_v, mism;
    logic [WIDTH-1:0]            inj_v;
    logic                        selftest;
    logic                        adv;

    assign adv   = en && !clr;
    // Fault injection flips only bit 0 of the captured complement.
    assign inj_v = WIDTH'(inj);

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_head
            assign ld_t[i] = d;
            assign ld_c[i] = ~d ^ inj_v;
            assign ld_v[i] = in_valid;
        end else begin : g_body
            assign ld_t[i] = t_a[i-1];
            assign ld_c[i] = c_a[i-1];
            assign ld_v[i] = v_a[i-1];
        end

        dff_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .en       (en),
            .clr      (clr),
            .chk_off  (selftest),
            .ld_t     (ld_t[i]),
            .ld_c     (ld_c[i]),
            .ld_v     (ld_v[i]),
            .t        (t_a[i]),
            .c        (c_a[i]),
            .v        (v_a[i]),
            .mismatch (mism[i])
        );
    end

    // Occupancy tracks popcount of the valid bits: entry minus exit per advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            occ <= '0;
        else if (clr)
            occ <= '0;
        else if (en)
            occ <= occ + OW'(in_valid) - OW'(v_a[DEPTH-1]);
    end

    // Sticky error: any stage holding an inconsistent pair, independent of en/clr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err <= 1'b0;
        else if (|mism)
            err <= 1'b1;
    end

    // Remembers that a mismatch was injected on purpose, so pair checks stand down.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            selftest <= 1'b0;
        else if (adv && inj)
            selftest <= 1'b1;
    end

    assign q         = t_a[DEPTH-1];
    assign qr        = c_a[DEPTH-1];
    assign out_valid = v_a[DEPTH-1];

endmodule

// File: doc/dff_pipe.md
# dff_pipe

Parametrised multi-stage, multi-bit successor to the single-bit complementary flip-flop. Each stage stores a true/complement pair, so the output pair can be checked for dual-rail consistency. The block adds:
- a valid bit per stage, a global stall enable and a synchronous flush;
- an occupancy counter;
- a sticky complement-mismatch error flag with a fault-injection input for self-test.

It sits in datapaths as a checked retiming and pipeline register chain.

## Interface
- WIDTH, 8, data width in bits (≥1)
- DEPTH, 3, number of pipeline stages (≥1)
- RESET_VAL, '0, WIDTH-bit value loaded into every true register on reset or flush
- clk  input  1  single clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- en  input  1  advance enable; 0 holds every stage
- clr  input  1  synchronous flush
- in_valid  input  1  marks d as valid data
- d  input  WIDTH  data in
- inj  input  1  test only; flips complement bit 0 on stage-0 capture
- q  output  WIDTH  true output of the last stage
- qr  output  WIDTH  complement output of the last stage
- out_valid  output  1  valid bit of the last stage
- occ  output  $clog2(DEPTH+1)  number of valid stages
- err  output  1  sticky complement-mismatch flag

## Operation
- Stage state, for each stage i:
  - t[i]: WIDTH-bit true register.
  - c[i]: WIDTH-bit complement register, physically separate from t[i] and never derived from it.
  - v[i]: 1-bit valid.
- Priority at each clock edge is rst > clr > en.
- rst, asynchronous:
  - t = RESET_VAL, c = ~RESET_VAL, v = 0.
  - occ = 0, err = 0.
  - Outputs become q = RESET_VAL, qr = ~RESET_VAL, out_valid = 0.
- clr = 1, synchronous:
  - Every stage loads t = RESET_VAL, c = ~RESET_VAL, v = 0, and occ = 0.
  - err is NOT cleared by clr; only rst clears it.
  - en and in_valid are ignored in that cycle.
- en = 1 and clr = 0, advance:
  - Stage 0 loads t[0] = d, c[0] = ~d ^ {{WIDTH-1{0}}, inj}, v[0] = in_valid.
  - Each stage i > 0 loads t[i] = t[i-1], c[i] = c[i-1], v[i] = v[i-1].
  - Data shifts regardless of valid bits.
- en = 0 and clr = 0, hold: all t, c, v and occ hold. The err update below still applies.
- occ:
  - On an advancing edge, occ += in_valid − v[DEPTH-1]. A simultaneous entry and exit leaves occ unchanged.
  - The invariant occ == popcount(v) must always hold.
  - occ never exceeds DEPTH and never underflows.
- err:
  - At every edge not under rst, err is set if any stage has t[i] != ~c[i]. The comparison uses the registered values present before that edge.
  - Once set, err stays set until rst.
- Outputs: q = t[DEPTH-1], qr = c[DEPTH-1], out_valid = v[DEPTH-1].
- DEPTH = 1 degenerates to a single checked register with valid and occ ∈ {0,1}.

## Timing
- All outputs are registered; there is no combinational path from any input to any output.
- Latency:
  - A sample presented at edge k appears on q/qr/out_valid after edge k+DEPTH−1 when en is high continuously.
  - Each en-low cycle adds one cycle of latency.
- err rises one edge after a mismatched pair is held in any stage.
  - A fault injected at edge k therefore raises err after edge k+1, independent of en.
- A flush takes effect at the edge where clr is sampled high. Data presented in the same cycle is discarded.
- Reset mid-operation:
  - Applies immediately and without a clock.
  - The first capture happens at the first rising edge with rst low.
  - Deasserting rst near a clock edge is the integrator's responsibility; the block contains no reset synchroniser.

## Structure
- Shared package dff_pkg holds:
  - a typedef for the stage record (true, complement, valid) as a struct parameterised by a WIDTH localparam;
  - a function computing the occupancy width, $clog2(DEPTH+1).
- Sub-module dff_stage: one stage with en/clr/load inputs and outputs t, c, v, mismatch.
  - dff_pipe instantiates DEPTH of these in a generate loop.
  - dff_pipe adds the occ counter and the err reduction/sticky register.
- Each stage carries a concurrent assertion, t == ~c, sampled on clk and disabled iff rst. It is used alongside err in simulation.

## Test plan
All scenarios use WIDTH=8, DEPTH=3, RESET_VAL=8'h00.
- Reset:
  - Stimulus: assert rst for 2 cycles mid-stream with 8'hA5 in flight.
  - Required: q = 8'h00, qr = 8'hFF, out_valid = 0, occ = 0, err = 0, immediately and without a clock edge.
- Streaming:
  - Stimulus: en = 1, in_valid = 1, d = 8'h11, 8'h22, 8'h33, 8'h44 on consecutive edges.
  - Required: after the 3rd edge q = 8'h11, qr = 8'hEE, out_valid = 1, occ = 3; on the next edge q = 8'h22 and occ stays at 3.
- Stall:
  - Stimulus: the same stream with en = 0 for 2 cycles after the 2nd edge.
  - Required: q, qr and occ hold during the stall; 8'h11 appears 2 cycles later than in the streaming case.
- Bubbles:
  - Stimulus: in_valid pattern 1,0,1 with d = 8'h01, 8'hFF, 8'h03.
  - Required: out_valid sequence 1,0,1; occ goes 1, 1, 2, then 2 after the exit edge.
- Flush:
  - Stimulus: clr = 1 for one edge with occ = 3 and en = 1, in_valid = 1, d = 8'h77 in that cycle.
  - Required: occ = 0, out_valid = 0, q = 8'h00, qr = 8'hFF; 8'h77 is never output; err is unchanged.
- Fault:
  - Stimulus: inj = 1 for one edge with d = 8'h5A.
  - Required: stage-0 c = 8'hA4; err = 1 one edge later and stays 1 through clr; err clears only on rst; qr = 8'hA4 while q = 8'h5A at the output.
